// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the word data memory: m0 has priority, m1 ages to avoid starvation.
// Optional DMEM_ARB_ALIGN_CHECK_EN adds m0_err/m1_err and suppresses misaligned accesses.
module dmem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 8,
  parameter int unsigned ADDR_W       = 32,
  localparam int unsigned DATA_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
`ifdef DMEM_ARB_ALIGN_CHECK_EN
  output logic              m0_err,
  output logic              m1_err,
`endif
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [7:0] STARVE_LIM8 = 8'(STARVE_LIMIT);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t      state;
  logic        owner;
  logic        owner_we;
  logic        owner_mis;
  logic [7:0]  starve_cnt;

  logic              any_req;
  logic              m1_wins;
  logic              win_we;
  logic              win_mis;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  // Arbitration decision, consumed only on IDLE edges
  assign any_req   = m0_req | m1_req;
  assign m1_wins   = m1_req & (~m0_req | (starve_cnt >= STARVE_LIM8));
  assign win_we    = m1_wins ? m1_we    : m0_we;
  assign win_addr  = m1_wins ? m1_addr  : m0_addr;
  assign win_wdata = m1_wins ? m1_wdata : m0_wdata;

`ifdef DMEM_ARB_ALIGN_CHECK_EN
  assign win_mis = |win_addr[1:0];
`else
  assign win_mis = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= 1'b0;
      owner_we   <= 1'b0;
      owner_mis  <= 1'b0;
      starve_cnt <= 8'd0;
      m0_gnt     <= 1'b0;
      m1_gnt     <= 1'b0;
      m0_rvalid  <= 1'b0;
      m1_rvalid  <= 1'b0;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_we     <= 1'b0;
      mem_re     <= 1'b0;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
      m0_err     <= 1'b0;
      m1_err     <= 1'b0;
`endif
    end else begin
      m0_gnt    <= 1'b0;
      m1_gnt    <= 1'b0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
      m0_err    <= 1'b0;
      m1_err    <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (any_req) begin
            state     <= ACCESS;
            owner     <= m1_wins;
            owner_we  <= win_we;
            owner_mis <= win_mis;
            mem_addr  <= win_addr;
            mem_wdata <= win_wdata;
            mem_we    <= win_we & ~win_mis;
            mem_re    <= ~win_we & ~win_mis;
            m0_gnt    <= ~m1_wins;
            m1_gnt    <= m1_wins;
            if (m1_wins) begin
              starve_cnt <= 8'd0;
            end else if (m1_req && starve_cnt != 8'hFF) begin
              starve_cnt <= starve_cnt + 8'd1;
            end
          end
        end
        ACCESS: begin
          // Edge ending ACCESS: memory write lands, read data is captured
          state <= IDLE;
          if (owner_mis) begin
`ifdef DMEM_ARB_ALIGN_CHECK_EN
            if (owner) m1_err <= 1'b1;
            else       m0_err <= 1'b1;
`endif
          end else if (!owner_we) begin
            if (owner) begin
              m1_rdata  <= mem_rdata;
              m1_rvalid <= 1'b1;
            end else begin
              m0_rdata  <= mem_rdata;
              m0_rvalid <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural word memory; STARVE_LIMIT set to 4.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we, mem_re;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
  logic        m0_err, m1_err;
`endif

  dmem_arbiter #(.STARVE_LIMIT(4), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    .m0_err(m0_err), .m1_err(m1_err),
`endif
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Word memory: combinational read, write on posedge; preload port used during reset
  logic [31:0] mem [0:255];
  logic        pl_we = 1'b0;
  logic [7:0]  pl_idx = 8'd0;
  logic [31:0] pl_data = 32'd0;
  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
    else if (pl_we) mem[pl_idx] <= pl_data;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          port;
    logic [31:0] addr;
    bit          we;
    bit          re;
    logic [31:0] wdata;
    int          cyc;
  } gnt_t;
  typedef struct {
    bit          port;
    logic [31:0] data;
    int          cyc;
  } rd_t;

  gnt_t gq[$];
  rd_t  rq[$];
  rd_t  eq[$];

  int checks = 0;
  int errors = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void miss(input string name, input int exp_cyc);
    checks++;
    errors++;
    $display("FAIL %s: event absent, expected at cycle %0d, now %0d", name, exp_cyc, cyc);
  endfunction

  task automatic eg(input bit p, input logic [31:0] a, input bit we, input bit re,
                    input logic [31:0] wd, input int c);
    gq.push_back('{p, a, we, re, wd, c});
  endtask

  task automatic er(input bit p, input logic [31:0] d, input int c);
    rq.push_back('{p, d, c});
  endtask

  task automatic ee(input bit p, input int c);
    eq.push_back('{p, 32'd0, c});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] idx, input logic [31:0] d);
    pl_we = 1'b1; pl_idx = idx; pl_data = d;
    tick();
    pl_we = 1'b0;
  endtask

  // Monitor: pops expected grants / read returns whenever the DUT presents them
  always @(negedge clk) begin : mon
    gnt_t g;
    rd_t  r;
    chk("mem_we_re_excl", 32'(mem_we & mem_re), 32'd0);
    if (m0_gnt | m1_gnt) begin
      if (gq.size() == 0) begin
        miss("unexpected_gnt", -1);
      end else begin
        g = gq.pop_front();
        chk("gnt_cycle", 32'(cyc), 32'(g.cyc));
        chk("gnt_port", 32'({m1_gnt, m0_gnt}), g.port ? 32'd2 : 32'd1);
        chk("mem_addr", mem_addr, g.addr);
        chk("mem_we", 32'(mem_we), 32'(g.we));
        chk("mem_re", 32'(mem_re), 32'(g.re));
        if (g.we) chk("mem_wdata", mem_wdata, g.wdata);
      end
    end else begin
      chk("idle_mem_strobes", 32'({mem_we, mem_re}), 32'd0);
      if (gq.size() != 0 && gq[0].cyc <= cyc) begin
        miss("gnt_missing", gq[0].cyc);
        void'(gq.pop_front());
      end
    end
    if (m0_rvalid | m1_rvalid) begin
      if (rq.size() == 0) begin
        miss("unexpected_rvalid", -1);
      end else begin
        r = rq.pop_front();
        chk("rvalid_cycle", 32'(cyc), 32'(r.cyc));
        chk("rvalid_port", 32'({m1_rvalid, m0_rvalid}), r.port ? 32'd2 : 32'd1);
        chk("rdata", r.port ? m1_rdata : m0_rdata, r.data);
      end
    end else if (rq.size() != 0 && rq[0].cyc <= cyc) begin
      miss("rvalid_missing", rq[0].cyc);
      void'(rq.pop_front());
    end
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    if (m0_err | m1_err) begin
      if (eq.size() == 0) begin
        miss("unexpected_err", -1);
      end else begin
        r = eq.pop_front();
        chk("err_cycle", 32'(cyc), 32'(r.cyc));
        chk("err_port", 32'({m1_err, m0_err}), r.port ? 32'd2 : 32'd1);
      end
    end else if (eq.size() != 0 && eq[0].cyc <= cyc) begin
      miss("err_missing", eq[0].cyc);
      void'(eq.pop_front());
    end
`endif
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_m0_gnt"}, 32'(m0_gnt), 32'd0);
    chk({tag, "_m1_gnt"}, 32'(m1_gnt), 32'd0);
    chk({tag, "_m0_rvalid"}, 32'(m0_rvalid), 32'd0);
    chk({tag, "_m1_rvalid"}, 32'(m1_rvalid), 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_mem_re"}, 32'(mem_re), 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_m0_rdata"}, m0_rdata, 32'd0);
    chk({tag, "_m1_rdata"}, m1_rdata, 32'd0);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    rst = 1'b1;
    m0_req = 1'b0; m0_we = 1'b0; m0_addr = 32'd0; m0_wdata = 32'd0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = 32'd0; m1_wdata = 32'd0;
    tick();
    preload(8'd4,  32'hDEADBEEF);
    preload(8'd16, 32'h0BADF00D);
    preload(8'd64, 32'hC0DE0000);
    preload(8'd65, 32'hC0DE0001);
    preload(8'd66, 32'hC0DE0002);
    preload(8'd67, 32'hC0DE0003);
    preload(8'd68, 32'hC0DE0004);
    chk_all_zero("reset");
    rst = 1'b0;
    tick(); tick();

    // A: m0 read 0x10
    n = cyc;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10;
    eg(1'b0, 32'h10, 1'b0, 1'b1, 32'd0, n + 1);
    er(1'b0, 32'hDEADBEEF, n + 2);
    tick(); m0_req = 1'b0;
    tick(); tick();

    // B: m1 write then read back 0x20
    n = cyc;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h20; m1_wdata = 32'h12345678;
    eg(1'b1, 32'h20, 1'b1, 1'b0, 32'h12345678, n + 1);
    tick(); m1_req = 1'b0;
    tick();
    m1_req = 1'b1; m1_we = 1'b0;
    eg(1'b1, 32'h20, 1'b0, 1'b1, 32'd0, n + 3);
    er(1'b1, 32'h12345678, n + 4);
    tick(); m1_req = 1'b0;
    tick(); tick();

    // C: simultaneous requests, m0 first
    n = cyc;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h10;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h20;
    eg(1'b0, 32'h10, 1'b0, 1'b1, 32'd0, n + 1);
    er(1'b0, 32'hDEADBEEF, n + 2);
    eg(1'b1, 32'h20, 1'b0, 1'b1, 32'd0, n + 3);
    er(1'b1, 32'h12345678, n + 4);
    tick(); m0_req = 1'b0;
    tick();
    tick(); m1_req = 1'b0;
    tick(); tick();

    // D: m0 streams reads while m1 waits; m1 wins once starve_cnt reaches 4
    n = cyc;
    eg(1'b0, 32'h100, 1'b0, 1'b1, 32'd0, n + 1);  er(1'b0, 32'hC0DE0000, n + 2);
    eg(1'b0, 32'h104, 1'b0, 1'b1, 32'd0, n + 3);  er(1'b0, 32'hC0DE0001, n + 4);
    eg(1'b0, 32'h108, 1'b0, 1'b1, 32'd0, n + 5);  er(1'b0, 32'hC0DE0002, n + 6);
    eg(1'b0, 32'h10C, 1'b0, 1'b1, 32'd0, n + 7);  er(1'b0, 32'hC0DE0003, n + 8);
    eg(1'b1, 32'h20,  1'b0, 1'b1, 32'd0, n + 9);  er(1'b1, 32'h12345678, n + 10);
    eg(1'b0, 32'h110, 1'b0, 1'b1, 32'd0, n + 11); er(1'b0, 32'hC0DE0004, n + 12);
    m0_we = 1'b0; m1_we = 1'b0; m1_addr = 32'h20;
    for (int t = 0; t < 12; t++) begin
      m0_req  = (t < 11);
      m1_req  = (t < 9);
      m0_addr = 32'h100 + 32'(4 * ((t / 2 > 4) ? 4 : t / 2));
      tick();
    end
    m0_req = 1'b0; m1_req = 1'b0;
    tick(); tick();

    // E: reset during ACCESS of an m0 write; write must not land
    n = cyc;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h40; m0_wdata = 32'hAAAA5555;
    tick();
    chk("E_mem_we_in_access", 32'(mem_we), 32'd1);
    chk("E_m0_gnt_in_access", 32'(m0_gnt), 32'd1);
    rst = 1'b1;
    #1;
    chk("E_mem_we_async_drop", 32'(mem_we), 32'd0);
    chk("E_m0_gnt_async_drop", 32'(m0_gnt), 32'd0);
    m0_req = 1'b0; m0_we = 1'b0;
    tick(); tick();
    chk_all_zero("E_after_reset");
    rst = 1'b0;
    tick();
    n = cyc;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h40;
    eg(1'b0, 32'h40, 1'b0, 1'b1, 32'd0, n + 1);
    er(1'b0, 32'h0BADF00D, n + 2);
    tick(); m0_req = 1'b0;
    tick(); tick();

    // F: misaligned m1 read 0x22
    n = cyc;
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h22;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
    eg(1'b1, 32'h22, 1'b0, 1'b0, 32'd0, n + 1);
    ee(1'b1, n + 2);
`else
    eg(1'b1, 32'h22, 1'b0, 1'b1, 32'd0, n + 1);
    er(1'b1, 32'h12345678, n + 2);
`endif
    tick(); m1_req = 1'b0;
    tick(); tick(); tick();

    chk("gnt_queue_drained", 32'(gq.size()), 32'd0);
    chk("rvalid_queue_drained", 32'(rq.size()), 32'd0);
    chk("err_queue_drained", 32'(eq.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
